// File: rtl/wb_interconnect_1xn.sv
// -----------------------------------------------------------------------------
// wb_interconnect_1xn
//   Single-master, N-slave Wishbone classic interconnect. A request from the
//   master is address-decoded, registered, and forwarded to exactly one slave.
//   The slave's ack and read data are registered back to the master. Unmapped
//   addresses and slaves that never ack get an error response (ack + ERR_DATA)
//   together with a one-cycle timeout_o pulse, so the master can never hang.
//
// Ports
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   m_adr_i/m_dat_i/m_we_i/
//   m_sel_i/m_stb_i/m_cyc_i      master request
//   m_dat_o, m_ack_o             registered response to master
//   s_adr_o/s_dat_o/s_we_o/
//   s_sel_o                      shared, registered slave request fields
//   s_stb_o, s_cyc_o             per-slave strobe/cycle (one-hot or zero)
//   s_dat_i, s_ack_i             per-slave read data (slice k) and ack
//   timeout_o                    one-cycle pulse on timeout or unmapped access
//   err_adr_o                    address of the most recent error
//
// Handshake: the master holds cyc/stb and its request fields steady until it
// sees m_ack_o (or drops cyc to abort). m_ack_o is high for exactly one cycle
// per accepted request. A slave is addressed while its s_cyc_o/s_stb_o are
// high and completes with a single-cycle s_ack_i; acks from unselected slaves
// are ignored.
// -----------------------------------------------------------------------------
module wb_interconnect_1xn #(
  parameter int unsigned                 N_SLAVES       = 4,
  parameter logic [N_SLAVES*32-1:0]      SLAVE_BASE     = {32'h3000_0000, 32'h2000_0000,
                                                          32'h1000_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0]      SLAVE_MASK     = {4{32'hF000_0000}},
  parameter int unsigned                 TIMEOUT_CYCLES = 255,
  parameter logic [31:0]                 ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic [31:0]              m_adr_i,
  input  logic [31:0]              m_dat_i,
  input  logic                     m_we_i,
  input  logic [3:0]               m_sel_i,
  input  logic                     m_stb_i,
  input  logic                     m_cyc_i,
  output logic [31:0]              m_dat_o,
  output logic                     m_ack_o,
  output logic [31:0]              s_adr_o,
  output logic [31:0]              s_dat_o,
  output logic                     s_we_o,
  output logic [3:0]               s_sel_o,
  output logic [N_SLAVES-1:0]      s_stb_o,
  output logic [N_SLAVES-1:0]      s_cyc_o,
  input  logic [N_SLAVES*32-1:0]   s_dat_i,
  input  logic [N_SLAVES-1:0]      s_ack_i,
  output logic                     timeout_o,
  output logic [31:0]              err_adr_o
);

  localparam int unsigned IDX_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] sel_idx_q;
  logic [31:0]      cnt_q;

  // Address decode; loop runs high-to-low so the lowest matching index wins.
  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic [N_SLAVES-1:0] hit_onehot;

  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if ((m_adr_i & SLAVE_MASK[k*32 +: 32]) == (SLAVE_BASE[k*32 +: 32] & SLAVE_MASK[k*32 +: 32])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
    for (int k = 0; k < N_SLAVES; k++) begin
      if (hit && (hit_idx == IDX_W'(k))) hit_onehot[k] = 1'b1;
    end
  end

  // Response mux: only the latched slave's ack/data are observed.
  logic        sel_ack;
  logic [31:0] sel_dat;

  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel_idx_q == IDX_W'(k)) begin
        sel_ack = s_ack_i[k];
        sel_dat = s_dat_i[k*32 +: 32];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      sel_idx_q <= '0;
      cnt_q     <= '0;
      m_dat_o   <= '0;
      m_ack_o   <= 1'b0;
      s_adr_o   <= '0;
      s_dat_o   <= '0;
      s_we_o    <= 1'b0;
      s_sel_o   <= '0;
      s_stb_o   <= '0;
      s_cyc_o   <= '0;
      timeout_o <= 1'b0;
      err_adr_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          m_ack_o   <= 1'b0;
          timeout_o <= 1'b0;
          if (m_cyc_i && m_stb_i) begin
            s_adr_o   <= m_adr_i;
            s_dat_o   <= m_dat_i;
            s_we_o    <= m_we_i;
            s_sel_o   <= m_sel_i;
            sel_idx_q <= hit_idx;
            if (hit) begin
              s_stb_o <= hit_onehot;
              s_cyc_o <= hit_onehot;
              state_q <= ACTIVE;
            end else begin
              m_dat_o   <= ERR_DATA;
              m_ack_o   <= 1'b1;
              timeout_o <= 1'b1;
              err_adr_o <= m_adr_i;
              state_q   <= RESP;
            end
          end
        end

        ACTIVE: begin
          // Priority: abort, then slave ack, then timeout.
          if (!m_cyc_i) begin
            s_stb_o <= '0;
            s_cyc_o <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (sel_ack) begin
            m_dat_o <= sel_dat;
            m_ack_o <= 1'b1;
            s_stb_o <= '0;
            s_cyc_o <= '0;
            cnt_q   <= '0;
            state_q <= RESP;
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            m_dat_o   <= ERR_DATA;
            m_ack_o   <= 1'b1;
            timeout_o <= 1'b1;
            err_adr_o <= s_adr_o;
            s_stb_o   <= '0;
            s_cyc_o   <= '0;
            cnt_q     <= '0;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        RESP: begin
          // Response cycle; new requests are re-sampled only back in IDLE.
          m_ack_o   <= 1'b0;
          timeout_o <= 1'b0;
          state_q   <= IDLE;
        end

        default: begin
          s_stb_o <= '0;
          s_cyc_o <= '0;
          m_ack_o <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_interconnect_1xn.sv
// -----------------------------------------------------------------------------
// tb_wb_interconnect_1xn
//   Directed bench: a table of transactions with hand-computed responses,
//   plus hand-written abort and mid-transaction reset sequences. Slaves are
//   modelled as acking a programmable number of cycles after their strobe
//   (0 = never ack). All driving and sampling happens on the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_interconnect_1xn;

  localparam int N  = 4;
  localparam int TO = 8;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0]   m_adr, m_dat_w;
  logic          m_we, m_stb, m_cyc;
  logic [3:0]    m_sel;
  logic [31:0]   m_dat_o;
  logic          m_ack_o;
  logic [31:0]   s_adr_o, s_dat_o;
  logic          s_we_o;
  logic [3:0]    s_sel_o;
  logic [N-1:0]  s_stb_o, s_cyc_o;
  logic [N*32-1:0] s_dat_i;
  logic [N-1:0]  s_ack_i;
  logic          timeout_o;
  logic [31:0]   err_adr_o;

  wb_interconnect_1xn #(.N_SLAVES(N), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat_w),
    .m_we_i   (m_we),
    .m_sel_i  (m_sel),
    .m_stb_i  (m_stb),
    .m_cyc_i  (m_cyc),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),
    .s_stb_o  (s_stb_o),
    .s_cyc_o  (s_cyc_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .timeout_o(timeout_o),
    .err_adr_o(err_adr_o)
  );

  // ---------------------------------------------------------------- slave model
  int          lat  [N];
  int          wcnt [N];
  logic [31:0] sdat [N];

  always_comb begin
    for (int k = 0; k < N; k++) s_dat_i[k*32 +: 32] = sdat[k];
  end

  // Ack is raised lat cycles after the strobe appears and held for one cycle.
  initial begin
    s_ack_i = '0;
    for (int k = 0; k < N; k++) begin
      lat[k] = 0; wcnt[k] = 0; sdat[k] = 32'h0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (s_ack_i[k]) begin
          s_ack_i[k] = 1'b0;
          wcnt[k]    = 0;
        end else if (s_stb_o[k]) begin
          wcnt[k]++;
          if (lat[k] != 0 && wcnt[k] == lat[k] + 1) s_ack_i[k] = 1'b1;
        end else begin
          wcnt[k] = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        we;
    logic [3:0]  sel;
    int          lat;
    logic [31:0] rdat;
    int          idx;      // expected slave, -1 = unmapped
    logic [31:0] exp_dat;
    int          exp_to;   // expected timeout_o pulses
    int          exp_cyc;  // cycles from request to m_ack_o
    int          exp_stbc; // cycles the slave strobe stays high
  } vec_t;

  // ---------------------------------------------------------------- driver
  task automatic run_txn(input string tag, input vec_t v);
    int          cyc, stbc, acks, tos, bad, tail;
    logic        got;
    logic [3:0]  stb_or, ssel, exp_mask;
    logic [31:0] dat_seen, sadr, sdat_seen;
    logic        swe;
    cyc = 0; stbc = 0; acks = 0; tos = 0; bad = 0; tail = -1; got = 1'b0;
    stb_or = '0; ssel = '0; dat_seen = '0; sadr = '0; sdat_seen = '0; swe = 1'b0;
    exp_mask = (v.idx < 0) ? 4'b0000 : 4'(1 << v.idx);
    if (v.idx >= 0) begin
      lat[v.idx]  = v.lat;
      sdat[v.idx] = v.rdat;
    end
    @(negedge clk);
    m_adr = v.adr; m_dat_w = v.wdat; m_we = v.we; m_sel = v.sel;
    m_cyc = 1'b1; m_stb = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tail < 0) cyc++;
      if (s_stb_o != '0) begin
        stbc++;
        sadr = s_adr_o; sdat_seen = s_dat_o; swe = s_we_o; ssel = s_sel_o;
      end
      stb_or |= s_stb_o;
      if ($countones(s_stb_o) > 1 || s_stb_o != s_cyc_o) bad++;
      if (m_ack_o) acks++;
      if (timeout_o) tos++;
      if (m_ack_o && tail < 0) begin
        got      = 1'b1;
        dat_seen = m_dat_o;
        tail     = 3;
        m_cyc    = 1'b0;
        m_stb    = 1'b0;
      end else if (tail > 0) begin
        tail--;
        if (tail == 0) break;
      end
    end
    m_cyc = 1'b0; m_stb = 1'b0;
    check({tag, " ack_seen"},   32'(got), 32'd1);
    check({tag, " ack_count"},  32'(acks), 32'd1);
    check({tag, " m_dat"},      dat_seen, v.exp_dat);
    check({tag, " latency"},    32'(cyc), 32'(v.exp_cyc));
    check({tag, " stb_cycles"}, 32'(stbc), 32'(v.exp_stbc));
    check({tag, " stb_mask"},   32'(stb_or), 32'(exp_mask));
    check({tag, " onehot"},     32'(bad), 32'd0);
    check({tag, " timeouts"},   32'(tos), 32'(v.exp_to));
    if (v.idx >= 0) check({tag, " s_adr"}, sadr, v.adr);
    if (v.we) begin
      check({tag, " s_we"},  32'(swe), 32'd1);
      check({tag, " s_dat"}, sdat_seen, v.wdat);
      check({tag, " s_sel"}, 32'(ssel), 32'(v.sel));
    end
    if (v.exp_to != 0) check({tag, " err_adr"}, err_adr_o, v.adr);
  endtask

  // ---------------------------------------------------------------- test body
  vec_t vecs[7];
  vec_t v;
  int   acks;

  initial begin
    vecs[0] = '{32'h1000_0040, 32'h0,         1'b0, 4'hF,    2, 32'h1234_5678,  1, 32'h1234_5678, 0, 4, 3};
    vecs[1] = '{32'h0000_0010, 32'hA5A5_A5A5, 1'b1, 4'b0011, 1, 32'h0BAD_0000,  0, 32'h0BAD_0000, 0, 3, 2};
    vecs[2] = '{32'h5000_0000, 32'h0,         1'b0, 4'hF,    0, 32'h0,         -1, 32'hDEAD_BEEF, 1, 1, 0};
    vecs[3] = '{32'h3000_0000, 32'h0,         1'b0, 4'hF,    0, 32'h3333_3333,  3, 32'hDEAD_BEEF, 1, 9, 8};
    vecs[4] = '{32'h2ABC_0008, 32'h0,         1'b0, 4'h1,    1, 32'hCAFE_F00D,  2, 32'hCAFE_F00D, 0, 3, 2};
    vecs[5] = '{32'h1FFF_FFFC, 32'h0,         1'b0, 4'hF,    5, 32'h0F0F_0F0F,  1, 32'h0F0F_0F0F, 0, 7, 6};
    vecs[6] = '{32'hF000_0000, 32'h0,         1'b0, 4'hF,    0, 32'h0,         -1, 32'hDEAD_BEEF, 1, 1, 0};

    rst_n = 1'b0;
    m_adr = '0; m_dat_w = '0; m_we = 1'b0; m_sel = '0; m_stb = 1'b0; m_cyc = 1'b0;
    #1;
    check("rst m_ack",     32'(m_ack_o), 32'd0);
    check("rst m_dat",     m_dat_o, 32'd0);
    check("rst s_stb",     32'(s_stb_o), 32'd0);
    check("rst s_cyc",     32'(s_cyc_o), 32'd0);
    check("rst timeout",   32'(timeout_o), 32'd0);
    check("rst err_adr",   err_adr_o, 32'd0);
    check("rst s_adr",     s_adr_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i]);
    end

    // Abort: master drops cyc in the same cycle slave 2 raises its ack.
    lat[2] = 1; sdat[2] = 32'h7777_7777;
    @(negedge clk);
    m_adr = 32'h2000_0100; m_we = 1'b0; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
    @(negedge clk);
    check("abort stb_up", 32'(s_stb_o), 32'b0100);
    @(negedge clk);
    m_cyc = 1'b0; m_stb = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m_ack_o) acks++;
      if (i == 0) check("abort stb_clr", 32'(s_stb_o), 32'd0);
    end
    check("abort no_ack", 32'(acks), 32'd0);
    v = '{32'h2000_0200, 32'h0, 1'b0, 4'hF, 1, 32'h2222_0001, 2, 32'h2222_0001, 0, 3, 2};
    run_txn("post_abort", v);

    // Reset while slave 1 is strobed and never answering.
    lat[1] = 0;
    @(negedge clk);
    m_adr = 32'h1000_0000; m_cyc = 1'b1; m_stb = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid stb_up", 32'(s_stb_o), 32'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid s_stb", 32'(s_stb_o), 32'd0);
    check("rst_mid s_cyc", 32'(s_cyc_o), 32'd0);
    check("rst_mid m_ack", 32'(m_ack_o), 32'd0);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    v = '{32'h1000_0040, 32'h0, 1'b0, 4'hF, 1, 32'h5A5A_0001, 1, 32'h5A5A_0001, 0, 3, 2};
    run_txn("post_reset", v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
